reg_bus_master: RTL and testbench
=================================

# reg_bus_master

Request-sequencing front end for the register control bank. Accepts register read/write commands from a host-side valid/ready stream and buffers them in a small FIFO. Drives them one at a time onto the register bank's sel/wr/addr/wdata port, honouring its ready signal, and returns read data on a valid/ready response stream. It sits directly upstream of the register bank and is its only bus master.

## Interface
Parameters:
- ADDR_WIDTH, 8, register address width; matches the register bank.
- DATA_WIDTH, 16, register data width; matches the register bank.
- FIFO_DEPTH, 4, request FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 16, max cycles waiting on bus_ready (only with timeout feature).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  host command valid.
- req_ready  out  1  FIFO not full; command accepted when req_valid & req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  register address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  transaction timed out.
- bus_sel  out  1  register bank select.
- bus_wr  out  1  register bank write strobe.
- bus_addr  out  ADDR_WIDTH  register bank address.
- bus_wdata  out  DATA_WIDTH  register bank write data.
- bus_rdata  in  DATA_WIDTH  register bank read data, valid the cycle after a read is sampled.
- bus_ready  in  1  register bank ready.

## Operation
- FSM states: IDLE, ISSUE, RDATA, RESP.
- IDLE: if the FIFO is non-empty, load the head into the bus registers and go to ISSUE.
- ISSUE:
  - bus_sel=1; bus_wr/addr/wdata held stable.
  - At an edge where bus_ready=1, the transfer completes and the FIFO pops.
  - A write then goes to IDLE; a read goes to RDATA.
  - While bus_ready=0, the FSM stays in ISSUE with all bus signals unchanged.
- RDATA: bus_sel=0; capture bus_rdata into rsp_rdata at the edge and go to RESP.
- RESP: rsp_valid=1 with rsp_rdata/rsp_err stable; on rsp_valid & rsp_ready, go to IDLE.
- Responses:
  - Writes produce no response unless they time out.
  - Responses come back strictly in request order; only one transaction is outstanding.
- Outside ISSUE, bus_sel, bus_wr, bus_addr and bus_wdata are 0.
- FIFO:
  - Push and pop in the same cycle are allowed when not full.
  - When full, req_ready=0 even if a pop occurs that cycle (no bypass).
  - The count is $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- Reset (asynchronous, mid-operation included):
  - FIFO flushed; FSM to IDLE.
  - bus_* outputs, rsp_valid, rsp_rdata and rsp_err all 0 immediately.
  - req_ready = 1 after reset (empty FIFO).
  - Any in-flight transaction is discarded.

## Timing
- Push at edge N → head visible at N+1 → ISSUE entered at N+2 (bus_sel high during cycle N+2).
- Write with bus_ready=1: one bus cycle; back-to-back writes issue every 2 cycles.
- Read with bus_ready=1: ISSUE at cycle k, RDATA at k+1, rsp_valid high from k+2.
- Read latency from request to rsp_valid is 4 cycles minimum; each bus_ready=0 cycle adds one.

## Configuration
- REG_BUS_MASTER_TIMEOUT_EN defined:
  - A counter (reset to 0 on entering ISSUE) increments each ISSUE cycle with bus_ready=0.
  - On reaching TIMEOUT_CYCLES: drop bus_sel, pop the FIFO, load rsp_rdata=0 and rsp_err=1, and go to RESP. This applies to reads and writes alike.
  - If bus_ready=1 in the same cycle the count is reached, the transfer completes normally.
- Undefined: no counter; ISSUE waits indefinitely; rsp_err is tied to 0.

## Structure
- Package reg_bus_pkg:
  - state enum (IDLE/ISSUE/RDATA/RESP);
  - request struct {wr, addr, wdata};
  - default ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module, reg_req_fifo: a parameterised synchronous FIFO with full/empty flags, async active-low reset and registered storage.

## Test plan
- Reset then write 0xBEEF to addr 0x10 with bus_ready=1 → bus_sel=1, bus_wr=1, bus_addr=0x10, bus_wdata=0xBEEF for exactly one cycle at N+2; no rsp_valid.
- Read addr 0x10 with the bank returning 0xBEEF → rsp_valid at N+4 with rsp_rdata=0xBEEF, rsp_err=0; held until rsp_ready.
- Push 5 writes back-to-back with bus_ready=0 and FIFO_DEPTH=4 → req_ready falls after the 4th push; the 5th is accepted only after the first pop.
- bus_ready low 3 cycles during a read → bus signals stable for 4 cycles; response arrives 3 cycles late with correct data.
- With REG_BUS_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, bus_ready stuck 0 on a read → bus_sel drops after 16 cycles; rsp_valid with rsp_err=1, rsp_rdata=0; the next queued command then issues.
- Assert rstn low mid-ISSUE with 3 commands queued → bus_sel=0 immediately; after release, req_ready=1, no bus activity, no response.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg
//   Shared types and default widths for the register bus master.
//   - bus_state_t : sequencer states (IDLE/ISSUE/RDATA/RESP)
//   - reg_req_t   : one queued register command {wr, addr, wdata}
//   - REG_BUS_ADDR_W / REG_BUS_DATA_W : default bank address/data widths
package reg_bus_pkg;

  localparam int REG_BUS_ADDR_W = 8;
  localparam int REG_BUS_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } bus_state_t;

  typedef struct packed {
    logic                      wr;
    logic [REG_BUS_ADDR_W-1:0] addr;
    logic [REG_BUS_DATA_W-1:0] wdata;
  } reg_req_t;

endpackage

// File: rtl/reg_bus_master_fifo.sv
// reg_req_fifo
//   Synchronous request FIFO with registered storage.
//   Ports:
//     clk, rstn          : clock, async active-low reset (flushes pointers/count)
//     push, push_data    : write request; ignored while full (no bypass on pop)
//     pop                : remove head; ignored while empty
//     head               : current head entry
//     full, empty        : occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
module reg_req_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master
//   Queues host register commands and replays them one at a time onto the
//   register bank bus; read data returns on the response stream in order.
//   Ports:
//     clk, rstn                          : clock, async active-low reset
//     req_valid/req_ready/req_wr/
//       req_addr/req_wdata               : host command stream
//     rsp_valid/rsp_ready/rsp_rdata/
//       rsp_err                          : host response stream
//     bus_sel/bus_wr/bus_addr/bus_wdata  : register bank request (registered)
//     bus_rdata/bus_ready                : register bank return
//   Optional feature macro: REG_BUS_MASTER_TIMEOUT_EN
//     defined   -> ISSUE aborts after TIMEOUT_CYCLES stalled cycles with
//                  an error response (reads and writes)
//     undefined -> ISSUE waits indefinitely, rsp_err tied low
//
//   state | meaning
//   IDLE  | waiting for a queued command; loads FIFO head onto the bus
//   ISSUE | bus_sel high, waiting for bus_ready
//   RDATA | read accepted by bank; capture bus_rdata
//   RESP  | rsp_valid high until the host takes it
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = REG_BUS_ADDR_W,
  parameter int DATA_WIDTH     = REG_BUS_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  bus_sel,
  output logic                  bus_wr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready
);

  localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("reg_bus_master: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  bus_state_t            state;
  logic [REQ_W-1:0]      head;
  logic                  head_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  tmo_hit;

  assign {head_wr, head_addr, head_wdata} = head;
  assign req_ready = ~fifo_full;
  // Head leaves the FIFO when the bank accepts it or the wait is abandoned.
  assign fifo_pop  = (state == ISSUE) & (bus_ready | tmo_hit);

  reg_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (req_valid),
    .push_data ({req_wr, req_addr, req_wdata}),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef REG_BUS_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  // Remaining stall budget; reaching zero on a stalled cycle is the
  // TIMEOUT_CYCLES-th stall, unless bus_ready wins in that same cycle.
  logic [TW-1:0] tmo_cnt;
  logic          rsp_err_q;

  assign tmo_hit = (state == ISSUE) & ~bus_ready & (tmo_cnt == '0);
  assign rsp_err = rsp_err_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bus_sel   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef REG_BUS_MASTER_TIMEOUT_EN
      tmo_cnt   <= '0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            bus_sel   <= 1'b1;
            bus_wr    <= head_wr;
            bus_addr  <= head_addr;
            bus_wdata <= head_wdata;
            state     <= ISSUE;
`ifdef REG_BUS_MASTER_TIMEOUT_EN
            tmo_cnt   <= TMO_LOAD;
`endif
          end
        end
        ISSUE: begin
          if (bus_ready) begin
            bus_sel   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            state     <= bus_wr ? IDLE : RDATA;
          end
`ifdef REG_BUS_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            bus_sel   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err_q <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt   <= tmo_cnt - TW'(1);
          end
`endif
        end
        RDATA: begin
          rsp_rdata <= bus_rdata;
          rsp_valid <= 1'b1;
`ifdef REG_BUS_MASTER_TIMEOUT_EN
          rsp_err_q <= 1'b0;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
`timescale 1ns/1ps
module tb_reg_bus_master;
  import reg_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_wr;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic        bus_sel, bus_wr, bus_ready;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata, bus_rdata;

  int total = 0;
  int bad   = 0;

  // Register bank / host environment controls
  bit          ready_rand  = 1'b0;
  bit          rsp_rand    = 1'b0;
  logic        ready_force = 1'b1;
  logic        rsp_force   = 1'b0;
  logic [15:0] bank_mem [256];
  reg_req_t    obs_bus_q [$];
  logic [16:0] obs_rsp_q [$];
  bit          rd_pend = 1'b0;
  logic [7:0]  rd_addr = 8'h00;

  reg_bus_master #(
    .ADDR_WIDTH(8), .DATA_WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_sel(bus_sel), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  // Bank and host-response environment: acts 1ns after each falling edge.
  initial begin : bank_env
    reg_req_t t;
    bus_ready = 1'b1;
    bus_rdata = 16'h0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rd_pend) begin
        bus_rdata = bank_mem[rd_addr];
        rd_pend   = 1'b0;
      end else begin
        bus_rdata = 16'($urandom);
      end
      bus_ready = ready_rand ? ($urandom_range(0, 9) < 7) : ready_force;
      rsp_ready = rsp_rand ? ($urandom_range(0, 9) < 6) : rsp_force;
      if (rstn && bus_sel && bus_ready) begin
        t.wr = bus_wr; t.addr = bus_addr; t.wdata = bus_wdata;
        obs_bus_q.push_back(t);
        if (bus_wr) bank_mem[bus_addr] = bus_wdata;
        else begin
          rd_pend = 1'b1;
          rd_addr = bus_addr;
        end
      end
      if (rstn && rsp_valid && rsp_ready) obs_rsp_q.push_back({rsp_err, rsp_rdata});
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic push_req(input logic wr, input logic [7:0] a, input logic [15:0] d);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL push_wait: req_ready=%b required 1 within 200 cycles", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h0; req_wdata = 16'h0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
    end
    total++;
    if ({bus_sel, bus_wr, bus_addr, bus_wdata} !== 26'h0) begin
      bad++; $display("FAIL reset_bus: got sel=%b wr=%b addr=%h wdata=%h required all 0",
                      bus_sel, bus_wr, bus_addr, bus_wdata);
    end
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 18'h0) begin
      bad++; $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h required all 0",
                      rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_write_single();
    bit rsp_seen = 1'b0;
    @(negedge clk);
    ready_force = 1'b1;
    push_req(1'b1, 8'h10, 16'hBEEF);                 // cycle N+1
    total++;
    if (bus_sel !== 1'b0) begin
      bad++; $display("FAIL wr_n1_sel: got %b required 0", bus_sel);
    end
    @(negedge clk);                                  // cycle N+2
    total++;
    if ({bus_sel, bus_wr, bus_addr, bus_wdata} !== {1'b1, 1'b1, 8'h10, 16'hBEEF}) begin
      bad++; $display("FAIL wr_issue: got sel=%b wr=%b addr=%h wdata=%h required 1 1 10 beef",
                      bus_sel, bus_wr, bus_addr, bus_wdata);
    end
    @(negedge clk);                                  // cycle N+3
    total++;
    if ({bus_sel, bus_wr, bus_addr, bus_wdata} !== 26'h0) begin
      bad++; $display("FAIL wr_one_cycle: got sel=%b addr=%h wdata=%h required 0",
                      bus_sel, bus_addr, bus_wdata);
    end
    repeat (4) begin
      if (rsp_valid !== 1'b0) rsp_seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (rsp_seen) begin
      bad++; $display("FAIL wr_no_rsp: got rsp_valid=1 required 0");
    end
  endtask

  task automatic test_read_single();
    logic [2:0] v;
    bit hold_ok = 1'b1;
    @(negedge clk);
    rsp_force = 1'b0;
    push_req(1'b0, 8'h10, 16'h0);                    // cycle N+1
    v[0] = rsp_valid;
    @(negedge clk); v[1] = rsp_valid;
    @(negedge clk); v[2] = rsp_valid;
    total++;
    if (v !== 3'b000) begin
      bad++; $display("FAIL rd_early_rsp: got valid N+1..N+3=%b required 000", v);
    end
    @(negedge clk);                                  // cycle N+4
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin
      bad++; $display("FAIL rd_rsp: got valid=%b err=%b rdata=%h required 1 0 beef",
                      rsp_valid, rsp_err, rsp_rdata);
    end
    repeat (3) begin
      @(negedge clk);
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 16'hBEEF}) hold_ok = 1'b0;
    end
    total++;
    if (!hold_ok) begin
      bad++; $display("FAIL rd_hold: got valid=%b rdata=%h required held 1 beef", rsp_valid, rsp_rdata);
    end
    rsp_force = 1'b1;
    @(negedge clk);
    rsp_force = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rd_rsp_drop: got valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sel_bits = 8'h0;
    bit addr_ok = 1'b1;
    bit rr_ok   = 1'b1;
    logic [7:0] exp_a;
    @(negedge clk);
    ready_force = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      sel_bits[c] = bus_sel;
      if (bus_sel === 1'b1) begin
        exp_a = 8'h20 + 8'((c - 2) / 2);
        if (bus_addr !== exp_a || bus_wr !== 1'b1) addr_ok = 1'b0;
      end
      if (c < 3) begin
        if (req_ready !== 1'b1) rr_ok = 1'b0;
        req_valid = 1'b1; req_wr = 1'b1;
        req_addr = 8'h20 + 8'(c); req_wdata = 16'hA000 + 16'(c);
      end else begin
        req_valid = 1'b0;
      end
    end
    total++;
    if (!rr_ok) begin
      bad++; $display("FAIL b2b_req_ready: got 0 during pushes required 1");
    end
    total++;
    if (sel_bits !== 8'b0101_0100) begin
      bad++; $display("FAIL b2b_sel_pattern: got %b required 01010100", sel_bits);
    end
    total++;
    if (!addr_ok) begin
      bad++; $display("FAIL b2b_addr: got out-of-order bus_addr required 20,21,22");
    end
  endtask

  task automatic test_read_stall();
    bit stable = 1'b1;
    logic [15:0] wd0 = 16'h0;
    @(negedge clk);
    ready_force = 1'b0; rsp_force = 1'b0;
    push_req(1'b0, 8'h10, 16'h1234);                 // cycle N+1
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);                                // cycles N+2..N+5
      if (c == 0) wd0 = bus_wdata;
      if ({bus_sel, bus_wr, bus_addr} !== {1'b1, 1'b0, 8'h10} || bus_wdata !== wd0) stable = 1'b0;
      if (c == 3) ready_force = 1'b1;
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL stall_bus_stable: got sel=%b wr=%b addr=%h required 1 0 10 for 4 cycles",
                      bus_sel, bus_wr, bus_addr);
    end
    @(negedge clk);                                  // cycle N+6
    total++;
    if (rsp_valid !== 1'b0 || bus_sel !== 1'b0) begin
      bad++; $display("FAIL stall_rdata_cycle: got valid=%b sel=%b required 0 0", rsp_valid, bus_sel);
    end
    @(negedge clk);                                  // cycle N+7
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 16'hBEEF}) begin
      bad++; $display("FAIL stall_rsp: got valid=%b err=%b rdata=%h required 1 0 beef",
                      rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_force = 1'b1;
    @(negedge clk);
    rsp_force = 1'b0;
  endtask

  task automatic test_fifo_full();
    bit rr_ok = 1'b1;
    bit held  = 1'b1;
    int n = 0;
    @(negedge clk);
    ready_force = 1'b0;
    obs_bus_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready !== 1'b1) rr_ok = 1'b0;
      req_valid = 1'b1; req_wr = 1'b1;
      req_addr = 8'h30 + 8'(i); req_wdata = 16'hC000 + 16'(i);
    end
    @(negedge clk);
    total++;
    if (!rr_ok) begin
      bad++; $display("FAIL full_first4: got req_ready=0 before 4th push required 1");
    end
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL full_after4: got req_ready=%b required 0", req_ready);
    end
    req_addr = 8'h34; req_wdata = 16'hC004;
    repeat (3) begin
      @(negedge clk);
      if (req_ready !== 1'b0) held = 1'b0;
    end
    ready_force = 1'b1;                              // pop at end of this cycle
    total++;
    if (!held) begin
      bad++; $display("FAIL full_held: got req_ready=1 while full required 0");
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL full_after_pop: got req_ready=%b required 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    while (obs_bus_q.size() < 5 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (obs_bus_q.size() != 5) begin
      bad++; $display("FAIL full_count: got %0d bus writes required 5", obs_bus_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (obs_bus_q[i].wr !== 1'b1 || obs_bus_q[i].addr !== 8'h30 + 8'(i) ||
            obs_bus_q[i].wdata !== 16'hC000 + 16'(i)) begin
          bad++; $display("FAIL full_order[%0d]: got wr=%b addr=%h wdata=%h required 1 %h %h", i,
                          obs_bus_q[i].wr, obs_bus_q[i].addr, obs_bus_q[i].wdata,
                          8'h30 + 8'(i), 16'hC000 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit quiet = 1'b1;
    @(negedge clk);
    ready_force = 1'b0; rsp_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b1;
      req_addr = 8'h40 + 8'(i); req_wdata = 16'hD000 + 16'(i);
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus_sel !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: got bus_sel=%b required 1", bus_sel);
    end
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({bus_sel, bus_wr, bus_addr, bus_wdata, rsp_valid} !== 27'h0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_immediate: got sel=%b addr=%h valid=%b req_ready=%b required 0 0 0 1",
                      bus_sel, bus_addr, rsp_valid, req_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    ready_force = 1'b1; rsp_force = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus_sel !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    rsp_force = 1'b0;
    total++;
    if (!quiet) begin
      bad++; $display("FAIL rst_mid_quiet: got activity after reset required none");
    end
  endtask

`ifdef REG_BUS_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int cnt = 0;
    int n   = 0;
    @(negedge clk);
    ready_force = 1'b0; rsp_force = 1'b0;
    push_req(1'b0, 8'h55, 16'h0);
    push_req(1'b1, 8'h56, 16'h7777);
    while (bus_sel === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    total++;
    if (cnt != 16) begin
      bad++; $display("FAIL tmo_sel_cycles: got %0d required 16", cnt);
    end
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 16'h0}) begin
      bad++; $display("FAIL tmo_rsp: got valid=%b err=%b rdata=%h required 1 1 0000",
                      rsp_valid, rsp_err, rsp_rdata);
    end
    ready_force = 1'b1; rsp_force = 1'b1;
    while (bus_sel !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ({bus_sel, bus_wr, bus_addr, bus_wdata} !== {1'b1, 1'b1, 8'h56, 16'h7777}) begin
      bad++; $display("FAIL tmo_next: got sel=%b wr=%b addr=%h wdata=%h required 1 1 56 7777",
                      bus_sel, bus_wr, bus_addr, bus_wdata);
    end
    repeat (4) @(negedge clk);
    rsp_force = 1'b0;
  endtask
`endif

  task automatic test_random();
    reg_req_t    exp_bus [$];
    logic [16:0] exp_rsp [$];
    logic [15:0] ref_mem [256];
    reg_req_t    r;
    logic        wr;
    logic [7:0]  a;
    logic [15:0] d;
    int          n = 0;
    int          nb, nr;
    @(negedge clk);
    for (int i = 0; i < 256; i++) ref_mem[i] = bank_mem[i];
    obs_bus_q.delete();
    obs_rsp_q.delete();
    ready_rand = 1'b1; rsp_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 7));
      d  = 16'($urandom);
      r.wr = wr; r.addr = a; r.wdata = d;
      exp_bus.push_back(r);
      if (wr) ref_mem[a] = d;
      else    exp_rsp.push_back({1'b0, ref_mem[a]});
      push_req(wr, a, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    while ((obs_bus_q.size() < exp_bus.size() || obs_rsp_q.size() < exp_rsp.size()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    total++;
    if (obs_bus_q.size() != exp_bus.size() || obs_rsp_q.size() != exp_rsp.size()) begin
      bad++; $display("FAIL rand_counts: got bus=%0d rsp=%0d required bus=%0d rsp=%0d",
                      obs_bus_q.size(), obs_rsp_q.size(), exp_bus.size(), exp_rsp.size());
    end
    nb = (obs_bus_q.size() < exp_bus.size()) ? obs_bus_q.size() : exp_bus.size();
    nr = (obs_rsp_q.size() < exp_rsp.size()) ? obs_rsp_q.size() : exp_rsp.size();
    for (int i = 0; i < nb; i++) begin
      total++;
      if (obs_bus_q[i].wr !== exp_bus[i].wr || obs_bus_q[i].addr !== exp_bus[i].addr ||
          (exp_bus[i].wr && obs_bus_q[i].wdata !== exp_bus[i].wdata)) begin
        bad++; $display("FAIL rand_bus[%0d]: got wr=%b addr=%h wdata=%h required wr=%b addr=%h wdata=%h",
                        i, obs_bus_q[i].wr, obs_bus_q[i].addr, obs_bus_q[i].wdata,
                        exp_bus[i].wr, exp_bus[i].addr, exp_bus[i].wdata);
      end
    end
    for (int i = 0; i < nr; i++) begin
      total++;
      if (obs_rsp_q[i] !== exp_rsp[i]) begin
        bad++; $display("FAIL rand_rsp[%0d]: got err/rdata=%h required %h", i, obs_rsp_q[i], exp_rsp[i]);
      end
    end
    ready_rand = 1'b0; rsp_rand = 1'b0;
    ready_force = 1'b1; rsp_force = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bank_mem[i] = 16'($urandom);
    test_reset();
    test_write_single();
    test_read_single();
    test_back_to_back();
    test_read_stall();
    test_fifo_full();
    test_reset_mid();
`ifdef REG_BUS_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
